// File: rtl/button_event_gen.sv
// Turns a debounced switch level into single-cycle press, release, long-press and
// auto-repeat events, plus an 8-bit wrapping press counter for debug display.
module button_event_gen #(
    parameter int LONG_CYCLES   = 12_500_000,
    parameter int REPEAT_CYCLES = 2_500_000
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_Switch,
    input  logic       i_Clear,
    output logic       o_Press,
    output logic       o_Release,
    output logic       o_Long,
    output logic       o_Repeat,
    output logic       o_Held,
    output logic [7:0] o_Press_Count,
    output logic [1:0] o_State
);

    localparam int MAX_CYCLES = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
    localparam int CW = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [CW-1:0] LONG_LAST   = CW'(LONG_CYCLES - 1);
    localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HELD   = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          prev_q;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          long_q, long_d;
    logic          repeat_q, repeat_d;
    logic [7:0]    count_q, count_d;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            prev_q    <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
            count_q   <= 8'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            prev_q    <= i_Switch;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            repeat_q  <= repeat_d;
            count_q   <= count_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_Switch && !prev_q) begin
                    state_d = ST_HELD;
                    cnt_d   = '0;
                    press_d = 1'b1;
                end
            end
            ST_HELD: begin
                // Release wins over a threshold hit on the same edge.
                if (!i_Switch) begin
                    state_d   = ST_IDLE;
                    cnt_d     = '0;
                    release_d = 1'b1;
                end else if (cnt_q == LONG_LAST) begin
                    state_d = ST_REPEAT;
                    cnt_d   = '0;
                    long_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_REPEAT: begin
                if (!i_Switch) begin
                    state_d   = ST_IDLE;
                    cnt_d     = '0;
                    release_d = 1'b1;
                end else if (cnt_q == REPEAT_LAST) begin
                    cnt_d    = '0;
                    repeat_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // A press coinciding with a clear leaves the count at 1, not 0.
    always_comb begin
        count_d = count_q;
        if (i_Clear) begin
            count_d = {7'd0, press_d};
        end else if (press_d) begin
            count_d = count_q + 8'd1;
        end
    end

    assign o_Press       = press_q;
    assign o_Release     = release_q;
    assign o_Long        = long_q;
    assign o_Repeat      = repeat_q;
    assign o_Held        = (state_q != ST_IDLE);
    assign o_Press_Count = count_q;
    assign o_State       = state_q;

endmodule

// File: tb/tb_button_event_gen.sv
// Randomized and directed bench for button_event_gen; outputs are compared each cycle
// against a hold-age model (cycles since the press edge) with LONG=8, REPEAT=4.
module tb_button_event_gen;

    localparam int LONG_CYCLES   = 8;
    localparam int REPEAT_CYCLES = 4;

    logic       clk;
    logic       rst_n;
    logic       sw;
    logic       clr;
    logic       press, rel, lng, rpt, held;
    logic [7:0] count;
    logic [1:0] state_dbg;

    int checks   = 0;
    int failures = 0;

    // Reference model: hold age counts edges since the press edge.
    logic       m_held;
    int         m_age;
    logic       m_prev;
    logic [7:0] m_count;
    logic       e_press, e_rel, e_long, e_rpt;

    button_event_gen #(
        .LONG_CYCLES  (LONG_CYCLES),
        .REPEAT_CYCLES(REPEAT_CYCLES)
    ) dut (
        .i_Clk        (clk),
        .i_Rst_L      (rst_n),
        .i_Switch     (sw),
        .i_Clear      (clr),
        .o_Press      (press),
        .o_Release    (rel),
        .o_Long       (lng),
        .o_Repeat     (rpt),
        .o_Held       (held),
        .o_Press_Count(count),
        .o_State      (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_reset();
        m_held  = 1'b0;
        m_age   = 0;
        m_prev  = 1'b0;
        m_count = 8'd0;
        e_press = 1'b0;
        e_rel   = 1'b0;
        e_long  = 1'b0;
        e_rpt   = 1'b0;
    endfunction

    function automatic void model_edge(input logic s, input logic c);
        logic pressed;
        pressed = 1'b0;
        e_press = 1'b0;
        e_rel   = 1'b0;
        e_long  = 1'b0;
        e_rpt   = 1'b0;
        if (m_held) begin
            if (!s) begin
                e_rel  = 1'b1;
                m_held = 1'b0;
            end else begin
                m_age = m_age + 1;
                if (m_age == LONG_CYCLES)
                    e_long = 1'b1;
                else if (m_age > LONG_CYCLES && ((m_age - LONG_CYCLES) % REPEAT_CYCLES) == 0)
                    e_rpt = 1'b1;
            end
        end else if (s && !m_prev) begin
            e_press = 1'b1;
            m_held  = 1'b1;
            m_age   = 0;
            pressed = 1'b1;
        end
        if (c)
            m_count = pressed ? 8'd1 : 8'd0;
        else if (pressed)
            m_count = m_count + 8'd1;
        m_prev = s;
    endfunction

    function automatic logic [12:0] exp_vec();
        return {e_press, e_rel, e_long, e_rpt, m_held, m_count};
    endfunction

    function automatic logic [12:0] dut_vec();
        return {press, rel, lng, rpt, held, count};
    endfunction

    // Drive inputs, take one clock edge, advance the model, then settle past the edge.
    task automatic cycle(input logic s, input logic c);
        sw  = s;
        clr = c;
        @(posedge clk);
        model_edge(s, c);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        sw    = 1'b0;
        clr   = 1'b0;
        model_reset();
        #23;
        checks++;
        if (dut_vec() !== 13'd0) begin
            $display("FAIL reset_state got=%h want=%h", dut_vec(), 13'd0);
            failures++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 1'b0);
            checks++;
            if (dut_vec() !== 13'd0) begin
                $display("FAIL idle_after_reset cyc=%0d got=%h want=%h", i, dut_vec(), 13'd0);
                failures++;
            end
        end
    endtask

    task automatic test_hold(input string name, input int len);
        for (int i = 0; i < len + 3; i++) begin
            cycle(i < len, 1'b0);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                $display("FAIL %s cyc=%0d got=%h want=%h", name, i, dut_vec(), exp_vec());
                failures++;
            end
        end
    endtask

    task automatic test_short_press();
        test_hold("short_press", 5);
        checks++;
        if (count !== 8'd1) begin
            $display("FAIL short_press_count got=%0d want=1", count);
            failures++;
        end
    endtask

    task automatic test_long_hold();
        test_hold("long_hold", 20);
    endtask

    task automatic test_release_on_threshold();
        test_hold("release_at_long", LONG_CYCLES);
        test_hold("release_at_repeat", LONG_CYCLES + REPEAT_CYCLES);
    endtask

    task automatic test_wrap_and_clear();
        cycle(1'b0, 1'b1);
        checks++;
        if (dut_vec() !== exp_vec()) begin
            $display("FAIL clear_idle got=%h want=%h", dut_vec(), exp_vec());
            failures++;
        end
        for (int n = 0; n < 256; n++) begin
            for (int ph = 0; ph < 2; ph++) begin
                cycle(ph == 0, 1'b0);
                checks++;
                if (dut_vec() !== exp_vec()) begin
                    $display("FAIL back_to_back n=%0d ph=%0d got=%h want=%h", n, ph, dut_vec(), exp_vec());
                    failures++;
                end
            end
        end
        checks++;
        if (count !== 8'd0) begin
            $display("FAIL wrap_count got=%0d want=0", count);
            failures++;
        end
        cycle(1'b1, 1'b1);
        checks++;
        if (dut_vec() !== exp_vec() || count !== 8'd1) begin
            $display("FAIL clear_with_press got=%h want=%h", dut_vec(), exp_vec());
            failures++;
        end
        cycle(1'b0, 1'b0);
        checks++;
        if (dut_vec() !== exp_vec()) begin
            $display("FAIL clear_with_press_release got=%h want=%h", dut_vec(), exp_vec());
            failures++;
        end
    endtask

    task automatic test_random();
        for (int b = 0; b < 14; b++) begin
            int len;
            int gap;
            len = $urandom_range(1, 22);
            gap = $urandom_range(1, 4);
            for (int i = 0; i < len + gap; i++) begin
                cycle(i < len, $urandom_range(0, 9) == 0);
                checks++;
                if (dut_vec() !== exp_vec()) begin
                    $display("FAIL random b=%0d cyc=%0d got=%h want=%h", b, i, dut_vec(), exp_vec());
                    failures++;
                end
            end
        end
    endtask

    task automatic test_reset_mid_repeat();
        for (int i = 0; i < 14; i++) begin
            cycle(1'b1, 1'b0);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                $display("FAIL pre_reset_hold cyc=%0d got=%h want=%h", i, dut_vec(), exp_vec());
                failures++;
            end
        end
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (dut_vec() !== 13'd0) begin
            $display("FAIL async_reset got=%h want=%h", dut_vec(), 13'd0);
            failures++;
        end
        #2;
        rst_n = 1'b1;
        cycle(1'b1, 1'b0);
        checks++;
        if (dut_vec() !== exp_vec() || press !== 1'b1) begin
            $display("FAIL press_after_reset got=%h want=%h", dut_vec(), exp_vec());
            failures++;
        end
        cycle(1'b0, 1'b0);
        checks++;
        if (dut_vec() !== exp_vec()) begin
            $display("FAIL release_after_reset got=%h want=%h", dut_vec(), exp_vec());
            failures++;
        end
    endtask

    initial begin
        test_reset();
        test_short_press();
        test_long_hold();
        test_release_on_threshold();
        test_wrap_and_clear();
        test_random();
        test_reset_mid_repeat();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/button_event_gen.md
# button_event_gen

Converts the debounced switch level from the debounce stage into single-cycle button events: press, release, long-press and auto-repeat. It sits directly downstream of the debouncer, one instance per button, in the same clock domain. Its pulses drive the game and VGA control logic, for example cursor moves and menu selection. It also keeps an 8-bit press counter for debug display.

## Interface
- LONG_CYCLES, default 12_500_000: number of cycles held before the long-press event. Legal range ≥ 2.
- REPEAT_CYCLES, default 2_500_000: period of auto-repeat pulses after a long press. Legal range ≥ 1.
- i_Clk  input  1  system clock. All logic runs on its rising edge.
- i_Rst_L  input  1  reset, asynchronous, active-low.
- i_Switch  input  1  debounced switch level. It is synchronous to i_Clk; 1 means pressed.
- i_Clear  input  1  synchronous clear of o_Press_Count.
- o_Press  output  1  one-cycle pulse on press.
- o_Release  output  1  one-cycle pulse on release.
- o_Long  output  1  one-cycle pulse when the hold reaches LONG_CYCLES.
- o_Repeat  output  1  one-cycle pulse every REPEAT_CYCLES after o_Long while the button stays held.
- o_Held  output  1  level; 1 while the state is not IDLE.
- o_Press_Count  output  8  number of presses, wrapping at 8 bits.

## Operation
- States:
  - IDLE: button up.
  - HELD: pressed, counting toward the long press.
  - REPEAT: long press done, generating repeat pulses.
- r_Prev holds i_Switch from the previous edge. A press edge is i_Switch=1 while r_Prev=0.
- One counter, width $clog2(max(LONG_CYCLES, REPEAT_CYCLES)). It is cleared on every state change.
- IDLE → HELD on a press edge:
  - o_Press is driven to 1.
  - The counter is set to 0.
  - o_Press_Count is incremented; 255 wraps to 0.
- HELD, i_Switch=1:
  - If counter == LONG_CYCLES-1: o_Long is driven to 1, the counter is set to 0, and the state goes to REPEAT.
  - Otherwise the counter increments.
- REPEAT, i_Switch=1:
  - If counter == REPEAT_CYCLES-1: o_Repeat is driven to 1 and the counter is set to 0.
  - Otherwise the counter increments.
- HELD or REPEAT, i_Switch=0:
  - o_Release is driven to 1 and the state goes to IDLE with the counter at 0.
  - Release has priority: no o_Long or o_Repeat is issued on that edge, even if the threshold is reached.
- IDLE with i_Switch=0: nothing happens. IDLE with i_Switch=1 and r_Prev=1 cannot occur except after reset; see below.
- At most one of o_Press, o_Release, o_Long and o_Repeat is high in any cycle.
- i_Clear:
  - o_Press_Count is set to 0.
  - If a press edge occurs on the same edge as i_Clear, o_Press_Count is set to 1.
- Counters never saturate. The threshold compare is an exact equality on the counter.

## Timing
- All outputs are registered. Let edge k be the first rising edge at which i_Switch=1 is sampled with r_Prev=0.
- o_Press and o_Held rise after edge k. o_Press falls after edge k+1. Latency from the i_Switch change to o_Press is 1 edge.
- o_Long is high for one cycle after edge k+LONG_CYCLES, provided i_Switch stays 1 through that edge.
- o_Repeat is high for one cycle after each edge k+LONG_CYCLES+n·REPEAT_CYCLES, for n ≥ 1.
- o_Release is high for one cycle after the first edge that samples i_Switch=0 while not IDLE. o_Held falls at the same edge.
- Reset (i_Rst_L=0) applies immediately, regardless of the clock:
  - All outputs go to 0, o_Press_Count goes to 0, the state goes to IDLE, and the counter and r_Prev go to 0.
  - Reset mid-hold gives no o_Release pulse.
  - If the button is still down at the first edge after deassertion, that edge counts as a press edge because r_Prev=0, so o_Press is issued.
- A button held for exactly 1 cycle gives o_Press at k and o_Release at k+1, back-to-back.

## Test plan
The bench uses LONG_CYCLES=8 and REPEAT_CYCLES=4.
- Reset, then i_Switch=0 for 20 cycles → all outputs stay 0 and o_Press_Count=0.
- i_Switch high for 5 cycles, then low → o_Press after edge k, o_Release after edge k+5, no o_Long, o_Held high for 5 cycles, o_Press_Count=1.
- Hold for 20 cycles → o_Long after edge k+8, o_Repeat after edges k+12 and k+16, o_Release after edge k+20.
- Release sampled exactly at edge k+8 → o_Release only, no o_Long. Release exactly at edge k+12 → o_Release only, no o_Repeat.
- 256 one-cycle presses separated by 1 idle cycle → o_Press_Count wraps to 0. Then i_Clear on the same edge as the next press edge → o_Press_Count=1.
- Assert i_Rst_L low mid-REPEAT between clock edges → outputs go to 0 immediately with no o_Release. Deassert with i_Switch=1 → o_Press after the first edge.
